// File: rtl/rv32i_controller.sv
// ---------------------------------------------------------------------------
// rv32i_controller
//   Main decode/control unit of the RV32I core. Turns the 32-bit instruction
//   word into datapath selects, the ALU operation, the data-memory request
//   and the next-PC source. Conditional branches are resolved here from the
//   ALU flags of rs1 - rs2. All decode is combinational, so outputs follow
//   i_inst and the flags with no latency.
//
//   A single run flag is cleared asynchronously by rst and set on the first
//   rising clock edge with rst low. While it is clear, every output that
//   changes architectural state is held inactive: memReq, memWrite and
//   regWrite are 0 and PCSrc is PC+4. The remaining outputs keep following
//   the decode.
//
// Ports
//   clk            in   1   system clock
//   rst            in   1   asynchronous, active-high reset
//   i_inst         in   32  instruction word
//   i_zero         in   1   ALU result == 0 (rs1 == rs2)
//   i_neg          in   1   signed rs1 < rs2
//   i_negU         in   1   unsigned rs1 < rs2
//   o_memReq       out  1   data memory access request (load or store)
//   o_memWrite     out  1   1 = store, 0 = load
//   o_memSize      out  2   00 byte, 01 half, 10 word
//   o_regWrite     out  1   register file write enable
//   o_PCSrc        out  2   00 PC+4, 01 PC+imm, 10 ALU result (JALR)
//   o_ALUSrc       out  1   ALU operand B: 0 rs2, 1 immediate
//   o_immSrc       out  3   000 I, 001 S, 010 B, 011 U, 100 J
//   o_immPlusSrc   out  1   immPlus adder: 0 PC+imm, 1 imm only (LUI)
//   o_readDataSrc  out  1   load extension: 0 sign, 1 zero
//   o_resultSrc    out  2   rd data: 00 ALU, 01 readData, 10 PC+4, 11 immPlus
//   o_ALUCtrl      out  4   ALU operation code
// ---------------------------------------------------------------------------
module rv32i_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_inst,
  input  logic        i_zero,
  input  logic        i_neg,
  input  logic        i_negU,
  output logic        o_memReq,
  output logic        o_memWrite,
  output logic [1:0]  o_memSize,
  output logic        o_regWrite,
  output logic [1:0]  o_PCSrc,
  output logic        o_ALUSrc,
  output logic [2:0]  o_immSrc,
  output logic        o_immPlusSrc,
  output logic        o_readDataSrc,
  output logic [1:0]  o_resultSrc,
  output logic [3:0]  o_ALUCtrl
);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Next-PC sources
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Writeback sources
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMMP = 2'b11;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = i_inst[6:0];
  assign funct3    = i_inst[14:12];
  assign funct7_b5 = i_inst[30];

  // Register addresses and immediates are consumed by the datapath, not here.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{i_inst[31], i_inst[29:15], i_inst[11:7]};

  // ALU operation for OP / OP-IMM. 'alt' is funct7[5] already qualified by
  // the caller: it chooses SUB over ADD and SRA over SRL.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                 input logic       alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch condition from the rs1 - rs2 flags. funct3 010/011 are not
  // defined branch encodings and never redirect the PC.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       zero,
                                        input logic       neg,
                                        input logic       neg_u);
    logic taken;
    unique case (f3)
      3'b000:  taken = zero;     // BEQ
      3'b001:  taken = ~zero;    // BNE
      3'b100:  taken = neg;      // BLT
      3'b101:  taken = ~neg;     // BGE
      3'b110:  taken = neg_u;    // BLTU
      3'b111:  taken = ~neg_u;   // BGEU
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Run flag: the only state in the block. Once set it stays set until the
  // next reset.
  logic run_q;
  logic run_d;

  always_comb begin
    run_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  // Raw decode, before gating by the run flag
  logic       dec_mem_req;
  logic       dec_mem_write;
  logic [1:0] dec_mem_size;
  logic       dec_reg_write;
  logic [1:0] dec_pc_src;
  logic       dec_alu_src;
  logic [2:0] dec_imm_src;
  logic       dec_imm_plus_src;
  logic       dec_read_data_src;
  logic [1:0] dec_result_src;
  logic [3:0] dec_alu_ctrl;

  always_comb begin
    // Defaults describe a NOP; FENCE, SYSTEM and unknown opcodes keep them.
    dec_mem_req       = 1'b0;
    dec_mem_write     = 1'b0;
    dec_mem_size      = SIZE_WORD;
    dec_reg_write     = 1'b0;
    dec_pc_src        = PC_PLUS4;
    dec_alu_src       = 1'b0;
    dec_imm_src       = IMM_I;
    dec_imm_plus_src  = 1'b0;
    dec_read_data_src = 1'b0;
    dec_result_src    = RES_ALU;
    dec_alu_ctrl      = ALU_ADD;

    unique case (opcode)
      OPC_OP: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b0;
        dec_result_src = RES_ALU;
        dec_alu_ctrl   = alu_from_funct3(funct3, funct7_b5);
      end

      OPC_OP_IMM: begin
        // There is no SUBI: bit 30 is part of the immediate except for the
        // shift-right form, where it distinguishes SRAI from SRLI.
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_imm_src    = IMM_I;
        dec_result_src = RES_ALU;
        dec_alu_ctrl   = alu_from_funct3(funct3,
                                         funct7_b5 && (funct3 == 3'b101));
      end

      OPC_LOAD: begin
        dec_mem_req       = 1'b1;
        dec_mem_write     = 1'b0;
        dec_mem_size      = funct3[1:0];
        dec_read_data_src = funct3[2];
        dec_alu_ctrl      = ALU_ADD;
        dec_alu_src       = 1'b1;
        dec_imm_src       = IMM_I;
        dec_reg_write     = 1'b1;
        dec_result_src    = RES_MEM;
      end

      OPC_STORE: begin
        dec_mem_req   = 1'b1;
        dec_mem_write = 1'b1;
        dec_mem_size  = funct3[1:0];
        dec_alu_ctrl  = ALU_ADD;
        dec_alu_src   = 1'b1;
        dec_imm_src   = IMM_S;
      end

      OPC_BRANCH: begin
        // The ALU computes rs1 - rs2 so the flags are valid in this cycle.
        dec_alu_ctrl = ALU_SUB;
        dec_alu_src  = 1'b0;
        dec_imm_src  = IMM_B;
        dec_pc_src   = branch_taken(funct3, i_zero, i_neg, i_negU)
                       ? PC_IMM : PC_PLUS4;
      end

      OPC_JAL: begin
        dec_imm_src    = IMM_J;
        dec_pc_src     = PC_IMM;
        dec_reg_write  = 1'b1;
        dec_result_src = RES_PC4;
      end

      OPC_JALR: begin
        dec_alu_ctrl   = ALU_ADD;
        dec_alu_src    = 1'b1;
        dec_imm_src    = IMM_I;
        dec_pc_src     = PC_ALU;
        dec_reg_write  = 1'b1;
        dec_result_src = RES_PC4;
      end

      OPC_LUI: begin
        dec_imm_src      = IMM_U;
        dec_imm_plus_src = 1'b1;
        dec_result_src   = RES_IMMP;
        dec_reg_write    = 1'b1;
      end

      OPC_AUIPC: begin
        dec_imm_src      = IMM_U;
        dec_imm_plus_src = 1'b0;
        dec_result_src   = RES_IMMP;
        dec_reg_write    = 1'b1;
      end

      default: begin
      end
    endcase
  end

  // Side-effect outputs are gated by the run flag. Because run_q clears
  // asynchronously, asserting rst suppresses them immediately.
  assign o_memReq      = dec_mem_req   & run_q;
  assign o_memWrite    = dec_mem_write & run_q;
  assign o_regWrite    = dec_reg_write & run_q;
  assign o_PCSrc       = run_q ? dec_pc_src : PC_PLUS4;

  assign o_memSize     = dec_mem_size;
  assign o_ALUSrc      = dec_alu_src;
  assign o_immSrc      = dec_imm_src;
  assign o_immPlusSrc  = dec_imm_plus_src;
  assign o_readDataSrc = dec_read_data_src;
  assign o_resultSrc   = dec_result_src;
  assign o_ALUCtrl     = dec_alu_ctrl;

endmodule

// File: tb/tb_rv32i_controller.sv
// ---------------------------------------------------------------------------
// tb_rv32i_controller
//   Directed and randomized checks of the RV32I control unit against a
//   behavioural reference model. The model decides branches from the actual
//   operand values and looks ALU codes up in a table indexed by funct3.
// ---------------------------------------------------------------------------
module tb_rv32i_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_inst;
  logic        i_zero;
  logic        i_neg;
  logic        i_negU;
  logic        o_memReq;
  logic        o_memWrite;
  logic [1:0]  o_memSize;
  logic        o_regWrite;
  logic [1:0]  o_PCSrc;
  logic        o_ALUSrc;
  logic [2:0]  o_immSrc;
  logic        o_immPlusSrc;
  logic        o_readDataSrc;
  logic [1:0]  o_resultSrc;
  logic [3:0]  o_ALUCtrl;

  int errors = 0;
  int checks = 0;
  bit run_m;   // bench's own view of whether the core is running

  always #5 clk = ~clk;

  rv32i_controller dut (
    .clk           (clk),
    .rst           (rst),
    .i_inst        (i_inst),
    .i_zero        (i_zero),
    .i_neg         (i_neg),
    .i_negU        (i_negU),
    .o_memReq      (o_memReq),
    .o_memWrite    (o_memWrite),
    .o_memSize     (o_memSize),
    .o_regWrite    (o_regWrite),
    .o_PCSrc       (o_PCSrc),
    .o_ALUSrc      (o_ALUSrc),
    .o_immSrc      (o_immSrc),
    .o_immPlusSrc  (o_immPlusSrc),
    .o_readDataSrc (o_readDataSrc),
    .o_resultSrc   (o_resultSrc),
    .o_ALUCtrl     (o_ALUCtrl)
  );

  // {memReq, memWrite, memSize, regWrite, PCSrc, ALUSrc, immSrc,
  //  immPlusSrc, readDataSrc, resultSrc, ALUCtrl}
  logic [18:0] dut_vec;
  assign dut_vec = {o_memReq, o_memWrite, o_memSize, o_regWrite, o_PCSrc,
                    o_ALUSrc, o_immSrc, o_immPlusSrc, o_readDataSrc,
                    o_resultSrc, o_ALUCtrl};

  // ALU code per funct3 for the non-alternate forms:
  // ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [3:0] ALU_OF_F3 [8] = '{4'd0, 4'd2, 4'd3, 4'd4,
                                           4'd5, 4'd6, 4'd8, 4'd9};

  function automatic logic [18:0] model(input logic [31:0] inst,
                                        input logic [31:0] a,
                                        input logic [31:0] b,
                                        input bit          run);
    logic       mreq, mwr, rw, asrc, ips, rds, taken;
    logic [1:0] msz, pcs, res;
    logic [2:0] imm, f3;
    logic [3:0] alu;
    f3    = inst[14:12];
    mreq  = 0; mwr = 0; msz = 2'b10; rw = 0; pcs = 2'b00; asrc = 0;
    imm   = 3'b000; ips = 0; rds = 0; res = 2'b00; alu = 4'd0;
    taken = 0;
    case (inst[6:0])
      7'b0110011: begin
        rw  = 1;
        alu = ALU_OF_F3[f3];
        if (inst[30] && f3 == 3'd0) alu = 4'd1;
        if (inst[30] && f3 == 3'd5) alu = 4'd7;
      end
      7'b0010011: begin
        rw = 1; asrc = 1;
        alu = ALU_OF_F3[f3];
        if (inst[30] && f3 == 3'd5) alu = 4'd7;
      end
      7'b0000011: begin
        mreq = 1; asrc = 1; rw = 1; res = 2'b01;
        msz = f3[1:0]; rds = f3[2];
      end
      7'b0100011: begin
        mreq = 1; mwr = 1; asrc = 1; imm = 3'b001; msz = f3[1:0];
      end
      7'b1100011: begin
        alu = 4'd1; imm = 3'b010;
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) <  $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a <  b);
          3'd7: taken = (a >= b);
          default: taken = 0;
        endcase
        pcs = taken ? 2'b01 : 2'b00;
      end
      7'b1101111: begin imm = 3'b100; pcs = 2'b01; rw = 1; res = 2'b10; end
      7'b1100111: begin asrc = 1; pcs = 2'b10; rw = 1; res = 2'b10; end
      7'b0110111: begin imm = 3'b011; ips = 1; res = 2'b11; rw = 1; end
      7'b0010111: begin imm = 3'b011; res = 2'b11; rw = 1; end
      default: ;
    endcase
    if (!run) begin
      mreq = 0; mwr = 0; rw = 0; pcs = 2'b00;
    end
    return {mreq, mwr, msz, rw, pcs, asrc, imm, ips, rds, res, alu};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] cur_a, cur_b;

  // Drive an instruction and operands between clock edges, then settle.
  task automatic apply(input logic [31:0] inst, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    i_inst = inst;
    cur_a  = a;
    cur_b  = b;
    i_zero = (a == b);
    i_neg  = ($signed(a) < $signed(b));
    i_negU = (a < b);
    #1;
  endtask

  task automatic check_all(input string tag);
    check(tag, {13'd0, dut_vec}, {13'd0, model(i_inst, cur_a, cur_b, run_m)});
  endtask

  // Opcodes used for random generation (last two are FENCE and SYSTEM)
  localparam logic [6:0] OPCODES [11] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                          7'b0100011, 7'b1100011, 7'b1101111,
                                          7'b1100111, 7'b0110111, 7'b0010111,
                                          7'b0001111, 7'b1110011};

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst    = 1'b1;
    run_m  = 0;
    i_inst = 32'h0;
    i_zero = 0; i_neg = 0; i_negU = 0;
    cur_a  = 0; cur_b = 0;

    // Held in reset: side effects suppressed, decode still visible
    apply(32'h002081B3, 32'd1, 32'd2);
    @(posedge clk); #1;
    check("rst_regwrite", {31'd0, o_regWrite}, 32'd0);
    check("rst_pcsrc", {30'd0, o_PCSrc}, 32'd0);
    check_all("rst_add_vec");

    // Release reset between edges: still not running until a rising edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("prerun_regwrite", {31'd0, o_regWrite}, 32'd0);
    @(posedge clk); #1;
    run_m = 1;
    check("run_regwrite", {31'd0, o_regWrite}, 32'd1);

    // add / sub
    apply(32'h002081B3, 32'd7, 32'd3);
    check("add_aluctrl", {28'd0, o_ALUCtrl}, 32'h0);
    check("add_alusrc", {31'd0, o_ALUSrc}, 32'd0);
    check("add_resultsrc", {30'd0, o_resultSrc}, 32'd0);
    apply(32'h402081B3, 32'd7, 32'd3);
    check("sub_aluctrl", {28'd0, o_ALUCtrl}, 32'h1);

    // srai honours bit 30, addi ignores it
    apply(32'h4030D093, 32'd0, 32'd0);
    check("srai_aluctrl", {28'd0, o_ALUCtrl}, 32'h7);
    apply(32'h40008093, 32'd0, 32'd0);
    check("addi_b30_aluctrl", {28'd0, o_ALUCtrl}, 32'h0);

    // lw
    apply(32'h0080A283, 32'd0, 32'd0);
    check("lw_memreq", {31'd0, o_memReq}, 32'd1);
    check("lw_memwrite", {31'd0, o_memWrite}, 32'd0);
    check("lw_memsize", {30'd0, o_memSize}, 32'd2);
    check("lw_resultsrc", {30'd0, o_resultSrc}, 32'd1);
    check("lw_immsrc", {29'd0, o_immSrc}, 32'd0);
    check("lw_alusrc", {31'd0, o_ALUSrc}, 32'd1);

    // sw
    apply(32'h0020A223, 32'd0, 32'd0);
    check("sw_memreq", {31'd0, o_memReq}, 32'd1);
    check("sw_memwrite", {31'd0, o_memWrite}, 32'd1);
    check("sw_immsrc", {29'd0, o_immSrc}, 32'd1);
    check("sw_regwrite", {31'd0, o_regWrite}, 32'd0);

    // beq taken / not taken, bltu taken, funct3=010 never taken
    apply(32'h00208063, 32'd5, 32'd5);
    check("beq_taken", {30'd0, o_PCSrc}, 32'd1);
    apply(32'h00208063, 32'd5, 32'd6);
    check("beq_not_taken", {30'd0, o_PCSrc}, 32'd0);
    apply(32'h0020E063, 32'd1, 32'hFFFF_FFFF);
    check("bltu_taken", {30'd0, o_PCSrc}, 32'd1);
    apply(32'h0020A063, 32'd5, 32'd5);
    check("br_f3_010", {30'd0, o_PCSrc}, 32'd0);

    // jalr
    apply(32'h000100E7, 32'd0, 32'd0);
    check("jalr_pcsrc", {30'd0, o_PCSrc}, 32'd2);
    check("jalr_resultsrc", {30'd0, o_resultSrc}, 32'd2);
    check("jalr_regwrite", {31'd0, o_regWrite}, 32'd1);

    // ecall behaves as a NOP
    apply(32'h00000073, 32'd0, 32'd0);
    check("ecall_vec", {13'd0, dut_vec}, {13'd0, 19'b0_0_10_0_00_0_000_0_0_00_0000});

    // Asynchronous reset mid-operation on a load: side effects drop at once
    apply(32'h0080A283, 32'd0, 32'd0);
    rst = 1'b1;
    run_m = 0;
    #1;
    check("async_rst_memreq", {31'd0, o_memReq}, 32'd0);
    check("async_rst_regwrite", {31'd0, o_regWrite}, 32'd0);
    check_all("async_rst_vec");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_m = 1;
    check("rerun_memreq", {31'd0, o_memReq}, 32'd1);

    // Randomized instructions and operands
    for (int n = 0; n < 400; n++) begin
      logic [31:0] inst, a, b;
      inst = $urandom;
      if ($urandom_range(0, 9) != 0)
        inst[6:0] = OPCODES[$urandom_range(0, 10)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      apply(inst, a, b);
      check_all($sformatf("rand_%0d_%h", n, inst));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
